// File: rtl/snoop_initiator.sv
// ACE snoop initiator: issues one AC snoop request, then collects the CR
// response and an optional cache line on CD, reporting the outcome.
module snoop_initiator #(
  parameter int unsigned C_ACE_ADDR_WIDTH = 44,
  parameter int unsigned C_ACE_DATA_WIDTH = 128,
  parameter int unsigned C_LINE_BYTES     = 64,
  parameter int unsigned C_TIMEOUT        = 1024
) (
  input  logic                          ace_aclk,
  input  logic                          ace_areset,
  // request
  input  logic                          i_start,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_addr,
  input  logic [3:0]                    i_acsnoop,
  input  logic [2:0]                    i_acprot,
  // AC channel
  output logic                          o_acvalid,
  input  logic                          i_acready,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
  output logic [3:0]                    o_acsnoop,
  output logic [2:0]                    o_acprot,
  // CR channel
  input  logic                          i_crvalid,
  output logic                          o_crready,
  input  logic [4:0]                    i_crresp,
  // CD channel
  input  logic                          i_cdvalid,
  output logic                          o_cdready,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_cddata,
  input  logic                          i_cdlast,
  // status / results
  output logic                          o_busy,
  output logic                          o_done,
  output logic [4:0]                    o_crresp,
  output logic [C_LINE_BYTES*8-1:0]     o_line,
  output logic                          o_line_valid,
  output logic                          o_timeout,
  output logic                          o_error
);

  localparam int unsigned LW    = C_LINE_BYTES * 8;
  localparam int unsigned DW    = C_ACE_DATA_WIDTH;
  localparam int unsigned BEATS = LW / DW;
  localparam int unsigned BW    = $clog2(BEATS) + 1;
  localparam int unsigned TW    = $clog2(C_TIMEOUT + 1);

  localparam logic [BW-1:0] BEATS_W   = BW'(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(C_TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_AC_REQ = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [C_ACE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                  snoop_q, snoop_d;
  logic [2:0]                  prot_q, prot_d;
  logic                        acvalid_q, acvalid_d;
  logic                        crready_q, crready_d;
  logic                        cdready_q, cdready_d;
  logic [4:0]                  crresp_q, crresp_d;
  logic [LW-1:0]               line_q, line_d;
  logic                        line_valid_q, line_valid_d;
  logic                        timeout_q, timeout_d;
  logic                        error_q, error_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic                        cr_got_q, cr_got_d;
  logic [TW-1:0]               tmo_q, tmo_d;

  logic ac_hs, cr_hs, cd_hs;

  // Handshakes use the registered valid/ready, so no input reaches a valid/ready output.
  assign ac_hs = acvalid_q & i_acready;
  assign cr_hs = crready_q & i_crvalid;
  assign cd_hs = cdready_q & i_cdvalid;

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    snoop_d      = snoop_q;
    prot_d       = prot_q;
    crresp_d     = crresp_q;
    line_d       = line_q;
    line_valid_d = line_valid_q;
    timeout_d    = timeout_q;
    error_d      = error_q;
    beat_d       = beat_q;
    cr_got_d     = cr_got_q;
    tmo_d        = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d       = i_addr;
          snoop_d      = i_acsnoop;
          prot_d       = i_acprot;
          crresp_d     = '0;
          line_valid_d = 1'b0;
          timeout_d    = 1'b0;
          error_d      = 1'b0;
          beat_d       = '0;
          cr_got_d     = 1'b0;
          tmo_d        = '0;
          state_d      = S_AC_REQ;
        end
      end

      S_AC_REQ: begin
        if (ac_hs) begin
          tmo_d   = '0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end

      S_RESP: begin
        if (cr_hs) begin
          crresp_d = i_crresp;
          cr_got_d = 1'b1;
        end
        if (cd_hs) begin
          for (int b = 0; b < int'(BEATS); b++) begin
            if (beat_q == BW'(b)) line_d[b*DW +: DW] = i_cddata;
          end
          beat_d = beat_q + BW'(1);
          // cdlast must mark exactly the final beat of the line
          if ((beat_q == LAST_BEAT) != i_cdlast) error_d = 1'b1;
        end
        // "no data" response after data already started is a protocol error
        if (cr_hs && !i_crresp[0] && (beat_d != '0)) error_d = 1'b1;

        if (cr_hs || cd_hs) tmo_d = '0;
        else                tmo_d = tmo_q + TW'(1);

        if (cr_got_d && (!crresp_d[0] || (beat_d == BEATS_W))) begin
          state_d = S_DONE;
        end else if (!(cr_hs || cd_hs) && (tmo_d == TMO_LIMIT)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    acvalid_d = (state_d == S_AC_REQ);
    crready_d = (state_d == S_RESP) && !cr_got_d;
    cdready_d = (state_d == S_RESP) && (beat_d < BEATS_W) && (!cr_got_d || crresp_d[0]);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      line_valid_d = crresp_d[0] && (beat_d == BEATS_W) && !error_d && !timeout_d;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge ace_aclk or posedge ace_areset) begin
    if (ace_areset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      snoop_q      <= '0;
      prot_q       <= '0;
      acvalid_q    <= 1'b0;
      crready_q    <= 1'b0;
      cdready_q    <= 1'b0;
      crresp_q     <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      beat_q       <= '0;
      cr_got_q     <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      snoop_q      <= snoop_d;
      prot_q       <= prot_d;
      acvalid_q    <= acvalid_d;
      crready_q    <= crready_d;
      cdready_q    <= cdready_d;
      crresp_q     <= crresp_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      timeout_q    <= timeout_d;
      error_q      <= error_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      beat_q       <= beat_d;
      cr_got_q     <= cr_got_d;
      tmo_q        <= tmo_d;
    end
  end

  assign o_acvalid    = acvalid_q;
  assign o_acaddr     = addr_q;
  assign o_acsnoop    = snoop_q;
  assign o_acprot     = prot_q;
  assign o_crready    = crready_q;
  assign o_cdready    = cdready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_crresp     = crresp_q;
  assign o_line       = line_q;
  assign o_line_valid = line_valid_q;
  assign o_timeout    = timeout_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_snoop_initiator.sv
// Directed bench for snoop_initiator (default widths, C_TIMEOUT = 16).
module tb_snoop_initiator;

  localparam int unsigned AW = 44;
  localparam int unsigned DW = 128;
  localparam int unsigned LW = 512;

  logic          ace_aclk = 1'b0;
  logic          ace_areset;
  logic          i_start;
  logic [AW-1:0] i_addr;
  logic [3:0]    i_acsnoop;
  logic [2:0]    i_acprot;
  logic          o_acvalid;
  logic          i_acready;
  logic [AW-1:0] o_acaddr;
  logic [3:0]    o_acsnoop;
  logic [2:0]    o_acprot;
  logic          i_crvalid;
  logic          o_crready;
  logic [4:0]    i_crresp;
  logic          i_cdvalid;
  logic          o_cdready;
  logic [DW-1:0] i_cddata;
  logic          i_cdlast;
  logic          o_busy;
  logic          o_done;
  logic [4:0]    o_crresp;
  logic [LW-1:0] o_line;
  logic          o_line_valid;
  logic          o_timeout;
  logic          o_error;

  int checks = 0;
  int passes = 0;

  snoop_initiator #(
    .C_ACE_ADDR_WIDTH(AW),
    .C_ACE_DATA_WIDTH(DW),
    .C_LINE_BYTES(64),
    .C_TIMEOUT(16)
  ) dut (
    .ace_aclk(ace_aclk), .ace_areset(ace_areset),
    .i_start(i_start), .i_addr(i_addr), .i_acsnoop(i_acsnoop), .i_acprot(i_acprot),
    .o_acvalid(o_acvalid), .i_acready(i_acready), .o_acaddr(o_acaddr),
    .o_acsnoop(o_acsnoop), .o_acprot(o_acprot),
    .i_crvalid(i_crvalid), .o_crready(o_crready), .i_crresp(i_crresp),
    .i_cdvalid(i_cdvalid), .o_cdready(o_cdready), .i_cddata(i_cddata), .i_cdlast(i_cdlast),
    .o_busy(o_busy), .o_done(o_done), .o_crresp(o_crresp), .o_line(o_line),
    .o_line_valid(o_line_valid), .o_timeout(o_timeout), .o_error(o_error)
  );

  always #5 ace_aclk = ~ace_aclk;

  function automatic logic [DW-1:0] nib(input logic [3:0] n);
    return {32{n}};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge ace_aclk);
    #1;
  endtask

  task automatic start_req(input logic [AW-1:0] a, input logic [3:0] s, input logic [2:0] p);
    i_start = 1'b1; i_addr = a; i_acsnoop = s; i_acprot = p;
    tick();
    i_start = 1'b0; i_addr = '1; i_acsnoop = 4'hF; i_acprot = 3'h7;
  endtask

  task automatic ac_accept();
    i_acready = 1'b1;
    tick();
    i_acready = 1'b0;
  endtask

  task automatic cd_beat(input logic [3:0] n, input logic last);
    i_cdvalid = 1'b1; i_cddata = nib(n); i_cdlast = last;
    tick();
    i_cdvalid = 1'b0; i_cdlast = 1'b0;
  endtask

  task automatic cr_send(input logic [4:0] r);
    i_crvalid = 1'b1; i_crresp = r;
    tick();
    i_crvalid = 1'b0;
  endtask

  task automatic test_reset();
    ace_areset = 1'b1;
    i_start = 0; i_addr = '0; i_acsnoop = 0; i_acprot = 0; i_acready = 0;
    i_crvalid = 0; i_crresp = 0; i_cdvalid = 0; i_cddata = '0; i_cdlast = 0;
    tick(); tick();
    checks++; if ({o_busy, o_done, o_acvalid, o_crready, o_cdready} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {o_busy, o_done, o_acvalid, o_crready, o_cdready});
    else passes++;
    checks++; if ({o_line_valid, o_timeout, o_error, o_crresp} !== 8'b0 || o_line !== '0)
      $display("FAIL reset_status: got lv=%b to=%b err=%b crresp=%h", o_line_valid, o_timeout, o_error, o_crresp);
    else passes++;
    ace_areset = 1'b0;
    tick();
  endtask

  // AC stall for two cycles, then CR first followed by four data beats.
  task automatic test_ac_hold_and_line();
    logic [LW-1:0] exp;
    start_req(44'h1000, 4'h1, 3'b010);
    for (int c = 0; c < 3; c++) begin
      checks++; if (o_acvalid !== 1'b1 || o_acaddr !== 44'h1000 || o_acsnoop !== 4'h1 || o_acprot !== 3'b010)
        $display("FAIL ac_hold_c%0d: got v=%b a=%h s=%h p=%h want 1 1000 1 2", c, o_acvalid, o_acaddr, o_acsnoop, o_acprot);
      else passes++;
      if (c < 2) tick();
    end
    ac_accept();
    checks++; if ({o_acvalid, o_crready, o_cdready} !== 3'b011)
      $display("FAIL resp_entry: got %b want 011", {o_acvalid, o_crready, o_cdready});
    else passes++;
    cr_send(5'h01);
    checks++; if ({o_crready, o_cdready} !== 2'b01 || o_crresp !== 5'h01)
      $display("FAIL cr_capture: got rdy=%b crresp=%h want 01 01", {o_crready, o_cdready}, o_crresp);
    else passes++;
    cd_beat(4'hA, 0); cd_beat(4'hB, 0); cd_beat(4'hC, 0);
    checks++; if (o_done !== 1'b0)
      $display("FAIL early_done: got %b want 0", o_done);
    else passes++;
    cd_beat(4'hD, 1);
    exp = {nib(4'hD), nib(4'hC), nib(4'hB), nib(4'hA)};
    checks++; if (o_done !== 1'b1 || o_line_valid !== 1'b1 || o_error !== 1'b0)
      $display("FAIL line_done: got done=%b lv=%b err=%b want 1 1 0", o_done, o_line_valid, o_error);
    else passes++;
    checks++; if (o_line !== exp)
      $display("FAIL line_data: got %h want %h", o_line, exp);
    else passes++;
    tick();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_line_valid !== 1'b1 || o_line !== exp)
      $display("FAIL line_hold: got done=%b busy=%b lv=%b", o_done, o_busy, o_line_valid);
    else passes++;
  endtask

  // Two beats before CR, one in the same cycle as CR, one after.
  task automatic test_data_around_cr();
    logic [LW-1:0] exp;
    start_req(44'h2040, 4'h1, 3'b000);
    ac_accept();
    cd_beat(4'h1, 0); cd_beat(4'h2, 0);
    checks++; if ({o_crready, o_cdready} !== 2'b11)
      $display("FAIL pre_cr_ready: got %b want 11", {o_crready, o_cdready});
    else passes++;
    i_crvalid = 1'b1; i_crresp = 5'h01;
    cd_beat(4'h3, 0);
    i_crvalid = 1'b0;
    checks++; if ({o_crready, o_cdready} !== 2'b01 || o_crresp !== 5'h01)
      $display("FAIL same_cycle_cr: got rdy=%b crresp=%h want 01 01", {o_crready, o_cdready}, o_crresp);
    else passes++;
    cd_beat(4'h4, 1);
    exp = {nib(4'h4), nib(4'h3), nib(4'h2), nib(4'h1)};
    checks++; if (o_done !== 1'b1 || o_line_valid !== 1'b1 || o_line !== exp || o_error !== 1'b0)
      $display("FAIL around_cr_line: got done=%b lv=%b err=%b line=%h", o_done, o_line_valid, o_error, o_line);
    else passes++;
    tick();
  endtask

  // Minimum latency: acready and crvalid (no data) already asserted at start.
  task automatic test_no_data();
    i_acready = 1'b1; i_crvalid = 1'b1; i_crresp = 5'h00;
    start_req(44'h3000, 4'h1, 3'b000);
    checks++; if (o_done !== 1'b0 || o_line_valid !== 1'b0 || o_crresp !== 5'h00)
      $display("FAIL nodata_c1: got done=%b lv=%b crresp=%h want 0 0 00", o_done, o_line_valid, o_crresp);
    else passes++;
    tick();
    checks++; if (o_done !== 1'b0 || o_crready !== 1'b1)
      $display("FAIL nodata_c2: got done=%b crready=%b want 0 1", o_done, o_crready);
    else passes++;
    tick();
    i_acready = 1'b0; i_crvalid = 1'b0;
    checks++; if (o_done !== 1'b1 || o_line_valid !== 1'b0 || o_crresp !== 5'h00 || o_error !== 1'b0)
      $display("FAIL nodata_done: got done=%b lv=%b crresp=%h err=%b want 1 0 00 0", o_done, o_line_valid, o_crresp, o_error);
    else passes++;
    tick();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL nodata_pulse: got done=%b busy=%b want 0 0", o_done, o_busy);
    else passes++;
  endtask

  task automatic test_cdlast_error();
    start_req(44'h4000, 4'h1, 3'b000);
    ac_accept();
    cr_send(5'h01);
    cd_beat(4'h5, 0);
    checks++; if (o_error !== 1'b0)
      $display("FAIL cdlast_pre: got %b want 0", o_error);
    else passes++;
    cd_beat(4'h6, 1);
    checks++; if (o_error !== 1'b1)
      $display("FAIL cdlast_beat2: got %b want 1", o_error);
    else passes++;
    cd_beat(4'h7, 0); cd_beat(4'h8, 1);
    checks++; if (o_done !== 1'b1 || o_error !== 1'b1 || o_line_valid !== 1'b0)
      $display("FAIL cdlast_done: got done=%b err=%b lv=%b want 1 1 0", o_done, o_error, o_line_valid);
    else passes++;
    tick();
  endtask

  task automatic test_cr_nodata_after_beat();
    start_req(44'h5000, 4'h1, 3'b000);
    ac_accept();
    cd_beat(4'h9, 0);
    cr_send(5'h00);
    checks++; if (o_done !== 1'b1 || o_error !== 1'b1 || o_line_valid !== 1'b0 || o_crresp !== 5'h00 || o_cdready !== 1'b0)
      $display("FAIL cr0_after_beat: got done=%b err=%b lv=%b crresp=%h cdrdy=%b", o_done, o_error, o_line_valid, o_crresp, o_cdready);
    else passes++;
    tick();
    checks++; if (o_error !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL err_sticky: got err=%b busy=%b want 1 0", o_error, o_busy);
    else passes++;
  endtask

  task automatic test_timeout();
    start_req(44'h6000, 4'h2, 3'b000);
    for (int c = 0; c < 15; c++) tick();
    checks++; if (o_acvalid !== 1'b1 || o_timeout !== 1'b0)
      $display("FAIL tmo_c15: got v=%b to=%b want 1 0", o_acvalid, o_timeout);
    else passes++;
    tick();
    checks++; if (o_acvalid !== 1'b0 || o_timeout !== 1'b1 || o_done !== 1'b1 || o_error !== 1'b0)
      $display("FAIL tmo_c16: got v=%b to=%b done=%b err=%b want 0 1 1 0", o_acvalid, o_timeout, o_done, o_error);
    else passes++;
    tick();
    checks++; if (o_done !== 1'b0 || o_timeout !== 1'b1)
      $display("FAIL tmo_hold: got done=%b to=%b want 0 1", o_done, o_timeout);
    else passes++;
  endtask

  task automatic test_reset_mid_and_busy_start();
    int done_seen;
    start_req(44'h7000, 4'h1, 3'b000);
    ac_accept();
    cd_beat(4'hA, 0); cd_beat(4'hB, 0);
    start_req(44'h7777, 4'h3, 3'b001);
    checks++; if (o_acvalid !== 1'b0 || o_acaddr !== 44'h7000 || o_crready !== 1'b1 || o_busy !== 1'b1)
      $display("FAIL busy_start_ignored: got v=%b a=%h crrdy=%b busy=%b", o_acvalid, o_acaddr, o_crready, o_busy);
    else passes++;
    #3 ace_areset = 1'b1;
    #1;
    checks++; if ({o_busy, o_done, o_acvalid, o_crready, o_cdready, o_error, o_line_valid} !== 7'b0 ||
                  o_line !== '0 || o_acaddr !== '0)
      $display("FAIL async_reset: got busy=%b crrdy=%b cdrdy=%b line=%h", o_busy, o_crready, o_cdready, o_line);
    else passes++;
    tick();
    ace_areset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_done !== 1'b0 || o_busy !== 1'b0) done_seen++;
    end
    checks++; if (done_seen != 0)
      $display("FAIL post_reset_quiet: got %0d active cycles want 0", done_seen);
    else passes++;
    i_acready = 1'b1; i_crvalid = 1'b1; i_crresp = 5'h00;
    start_req(44'h8000, 4'h1, 3'b000);
    checks++; if (o_acaddr !== 44'h8000 || o_acvalid !== 1'b1)
      $display("FAIL post_reset_start: got a=%h v=%b want 8000 1", o_acaddr, o_acvalid);
    else passes++;
    tick(); tick();
    i_acready = 1'b0; i_crvalid = 1'b0;
    checks++; if (o_done !== 1'b1 || o_error !== 1'b0 || o_timeout !== 1'b0)
      $display("FAIL post_reset_done: got done=%b err=%b to=%b want 1 0 0", o_done, o_error, o_timeout);
    else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_ac_hold_and_line();
    test_data_around_cr();
    test_no_data();
    test_cdlast_error();
    test_cr_nodata_after_beat();
    test_timeout();
    test_reset_mid_and_busy_start();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
